// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and HI/LO sequencing control for a classic 5-stage pipeline.
//
// The block detects two kinds of hazard:
//   - load-use: the ID instruction reads a register that a load in EX writes.
//   - HI/LO: the ID instruction touches HI/LO, or starts a new multiply or
//     divide, while the HI/LO unit is still working.
// A hazard stalls PC and IF/ID and inserts a bubble into ID/EX. A branch
// taken in EX flushes IF/ID instead, and this overrides any stall in the same
// cycle.
//
// The HI/LO unit is a small FSM (IDLE / MUL / DIV) with a down-counter. The
// counter holds the remaining cycles minus one. md_done is high during the
// last cycle of an operation, and a new operation may be accepted in that
// same cycle so that two operations run back-to-back.
//
// Parameters
//   MUL_CYCLES    total cycles of a MULT/MULTU (1..63)
//   DIV_CYCLES    total cycles of a DIV/DIVU   (1..63)
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous, active-low reset
//   id_rs/id_rt   source register numbers of the ID instruction
//   id_uses_rs/rt ID instruction reads rs / rt
//   id_uses_hilo  ID instruction is MFHI/MFLO/MTHI/MTLO
//   id_md_start   ID instruction is MULT/MULTU/DIV/DIVU
//   id_md_is_div  qualifies id_md_start: 1 = divide, 0 = multiply
//   ex_memrd      EX instruction is a load
//   ex_wa         destination register of the EX instruction
//   ex_br_taken   branch/jump resolved taken in EX
//   stall_if/id   hold PC and IF/ID
//   bubble_ex     insert NOP into ID/EX
//   flush_id      replace IF/ID with NOP
//   md_busy       HI/LO unit occupied
//   md_done       last cycle of the current operation (HI/LO write enable)
//   md_cnt        remaining cycles of the current operation, minus one
//   stall_cycles  saturating count of cycles with stall_id = 1
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_uses_hilo,
    input  logic        id_md_start,
    input  logic        id_md_is_div,
    input  logic        ex_memrd,
    input  logic [4:0]  ex_wa,
    input  logic        ex_br_taken,
    output logic        stall_if,
    output logic        stall_id,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        md_busy,
    output logic        md_done,
    output logic [5:0]  md_cnt,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;

    logic busy;
    logic done;
    logic load_use;
    logic hilo_haz;
    logic stall;
    logic accept;

    // Hazard detection and issue decision.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        // The last cycle has no hazard: the HI/LO write and any MFHI/MFLO
        // read in ID are forwarded downstream.
        done     = busy && (md_cnt_q == 6'd0);
        load_use = ex_memrd && (ex_wa != 5'd0) &&
                   ((id_uses_rs && (id_rs == ex_wa)) ||
                    (id_uses_rt && (id_rt == ex_wa)));
        hilo_haz = busy && !done && (id_uses_hilo || id_md_start);
        // A taken branch squashes the ID instruction, so it must not stall
        // and must not start a wrong-path multiply or divide.
        stall    = !ex_br_taken && (load_use || hilo_haz);
        accept   = id_md_start && !stall && !ex_br_taken && (!busy || done);
    end

    // Next-state logic for the HI/LO FSM and the stall counter.
    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves it
        // unassigned and no latch is inferred.
        state_d        = state_q;
        md_cnt_d       = md_cnt_q;
        stall_cycles_d = stall_cycles_q;

        if (accept) begin
            // This also covers the back-to-back case, where the new
            // operation is loaded in the done cycle of the previous one.
            state_d  = id_md_is_div ? ST_DIV : ST_MUL;
            md_cnt_d = id_md_is_div ? DIV_LOAD : MUL_LOAD;
        end else if (done) begin
            state_d  = ST_IDLE;
            md_cnt_d = 6'd0;
        end else if (busy) begin
            md_cnt_d = md_cnt_q - 6'd1;
        end

        if (stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments. All flops update
    // together at the edge, so no flop sees another flop's new value early.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            md_cnt_q       <= 6'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            md_cnt_q       <= md_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_if     = stall;
    assign stall_id     = stall;
    assign bubble_ex    = stall;
    assign flush_id     = ex_br_taken;
    assign md_busy      = busy;
    assign md_done      = done;
    assign md_cnt       = md_cnt_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl with its default parameters
// (MUL_CYCLES = 4, DIV_CYCLES = 32). Inputs change 1 ns after each rising
// edge. Outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_wa;
    logic        id_uses_rs, id_uses_rt, id_uses_hilo;
    logic        id_md_start, id_md_is_div;
    logic        ex_memrd, ex_br_taken;
    logic        stall_if, stall_id, bubble_ex, flush_id;
    logic        md_busy, md_done;
    logic [5:0]  md_cnt;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_uses_hilo (id_uses_hilo),
        .id_md_start  (id_md_start),
        .id_md_is_div (id_md_is_div),
        .ex_memrd     (ex_memrd),
        .ex_wa        (ex_wa),
        .ex_br_taken  (ex_br_taken),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .bubble_ex    (bubble_ex),
        .flush_id     (flush_id),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .md_cnt       (md_cnt),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs = 5'd0; id_rt = 5'd0; ex_wa = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_uses_hilo = 1'b0;
        id_md_start = 1'b0; id_md_is_div = 1'b0;
        ex_memrd = 1'b0; ex_br_taken = 1'b0;
    endtask

    // Start a new cycle: just after the rising edge, with inputs cleared.
    task automatic cycle_start();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        // ---------------- reset state ----------------
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  32'(md_busy), 32'd0);
        check("rst_done",  32'(md_done), 32'd0);
        check("rst_cnt",   32'(md_cnt), 32'd0);
        check("rst_sc",    32'(stall_cycles), 32'd0);
        check("rst_stall", 32'(stall_id), 32'd0);
        check("rst_flush", 32'(flush_id), 32'd0);
        rst = 1'b1;

        // ---------------- load-use on rs ----------------
        cycle_start();
        ex_memrd = 1'b1; ex_wa = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        @(negedge clk);
        check("lu_stall_if", 32'(stall_if), 32'd1);
        check("lu_stall_id", 32'(stall_id), 32'd1);
        check("lu_bubble",   32'(bubble_ex), 32'd1);
        exp_sc++;
        cycle_start();
        @(negedge clk);
        check("lu_release", 32'(stall_id), 32'd0);
        check("lu_sc",      32'(stall_cycles), 32'(exp_sc));

        // r0 is never a hazard
        cycle_start();
        ex_memrd = 1'b1; ex_wa = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        @(negedge clk);
        check("lu_r0", 32'(stall_id), 32'd0);

        // load-use on rt
        cycle_start();
        ex_memrd = 1'b1; ex_wa = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        @(negedge clk);
        check("lu_rt", 32'(stall_id), 32'd1);
        exp_sc++;

        // same register match, but rt is not read
        cycle_start();
        ex_memrd = 1'b1; ex_wa = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b0;
        @(negedge clk);
        check("lu_rt_unused", 32'(stall_id), 32'd0);

        // register match, but EX is not a load
        cycle_start();
        ex_memrd = 1'b0; ex_wa = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        @(negedge clk);
        check("lu_not_load", 32'(stall_id), 32'd0);

        // ---------------- branch priority in IDLE ----------------
        cycle_start();
        ex_br_taken = 1'b1; ex_memrd = 1'b1; ex_wa = 5'd8; id_rs = 5'd8;
        id_uses_rs = 1'b1; id_md_start = 1'b1; id_md_is_div = 1'b1;
        @(negedge clk);
        check("br_flush", 32'(flush_id), 32'd1);
        check("br_stall", 32'(stall_id), 32'd0);
        check("br_bubble", 32'(bubble_ex), 32'd0);
        cycle_start();
        @(negedge clk);
        check("br_no_start", 32'(md_busy), 32'd0);
        check("br_sc", 32'(stall_cycles), 32'(exp_sc));

        // ---------------- DIV then MFLO ----------------
        cycle_start();
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        @(negedge clk);
        check("div_issue_stall", 32'(stall_id), 32'd0);
        for (int k = 1; k <= 32; k++) begin
            cycle_start();
            id_uses_hilo = 1'b1;
            @(negedge clk);
            check($sformatf("div_busy_%0d", k), 32'(md_busy), 32'd1);
            check($sformatf("div_cnt_%0d", k),  32'(md_cnt), 32'(32 - k));
            check($sformatf("div_done_%0d", k), 32'(md_done), (k == 32) ? 32'd1 : 32'd0);
            check($sformatf("mflo_stall_%0d", k), 32'(stall_id), (k < 32) ? 32'd1 : 32'd0);
            if (k < 32) exp_sc++;
        end
        cycle_start();
        @(negedge clk);
        check("div_idle_busy", 32'(md_busy), 32'd0);
        check("div_idle_cnt",  32'(md_cnt), 32'd0);
        check("div_idle_done", 32'(md_done), 32'd0);
        check("div_sc",        32'(stall_cycles), 32'(exp_sc));

        // ---------------- DIV, in-flight events, back-to-back MULT ----------------
        cycle_start();
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            cycle_start();
            if (k == 5) begin
                id_md_start = 1'b1;
            end
            if (k == 10) begin
                id_md_start = 1'b1; ex_br_taken = 1'b1;
            end
            if (k == 32) begin
                id_md_start = 1'b1; id_md_is_div = 1'b0;
            end
            @(negedge clk);
            check($sformatf("b2b_busy_%0d", k), 32'(md_busy), 32'd1);
            check($sformatf("b2b_cnt_%0d", k),  32'(md_cnt), 32'(32 - k));
            check($sformatf("b2b_done_%0d", k), 32'(md_done), (k == 32) ? 32'd1 : 32'd0);
            if (k == 5) begin
                check("b2b_md_start_stall", 32'(stall_id), 32'd1);
                exp_sc++;
            end
            if (k == 10) begin
                check("b2b_br_flush", 32'(flush_id), 32'd1);
                check("b2b_br_stall", 32'(stall_id), 32'd0);
            end
            if (k == 32) begin
                check("b2b_issue_stall", 32'(stall_id), 32'd0);
            end
        end
        for (int k = 1; k <= 4; k++) begin
            cycle_start();
            @(negedge clk);
            check($sformatf("mul_busy_%0d", k), 32'(md_busy), 32'd1);
            check($sformatf("mul_cnt_%0d", k),  32'(md_cnt), 32'(4 - k));
            check($sformatf("mul_done_%0d", k), 32'(md_done), (k == 4) ? 32'd1 : 32'd0);
        end
        cycle_start();
        @(negedge clk);
        check("mul_idle", 32'(md_busy), 32'd0);
        check("b2b_sc", 32'(stall_cycles), 32'(exp_sc));

        // ---------------- reset mid-DIV ----------------
        cycle_start();
        id_md_start = 1'b1; id_md_is_div = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cycle_start();
            @(negedge clk);
        end
        check("rdiv_cnt17", 32'(md_cnt), 32'd17);
        #1;
        rst = 1'b0;
        ex_memrd = 1'b1; ex_wa = 5'd3; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        check("rdiv_busy",  32'(md_busy), 32'd0);
        check("rdiv_cnt",   32'(md_cnt), 32'd0);
        check("rdiv_done",  32'(md_done), 32'd0);
        check("rdiv_sc",    32'(stall_cycles), 32'd0);
        check("rdiv_stall_eq", 32'(stall_id), 32'd1);
        @(posedge clk);
        #1;
        check("rdiv_hold_sc", 32'(stall_cycles), 32'd0);
        clear_inputs();
        rst = 1'b1;
        exp_sc = 0;
        @(negedge clk);
        check("rdiv_post_busy", 32'(md_busy), 32'd0);
        check("rdiv_post_done", 32'(md_done), 32'd0);
        cycle_start();
        id_md_start = 1'b1; id_md_is_div = 1'b0;
        @(negedge clk);
        check("rmul_issue_stall", 32'(stall_id), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            cycle_start();
            @(negedge clk);
            check($sformatf("rmul_cnt_%0d", k),  32'(md_cnt), 32'(4 - k));
            check($sformatf("rmul_done_%0d", k), 32'(md_done), (k == 4) ? 32'd1 : 32'd0);
        end
        cycle_start();
        @(negedge clk);
        check("rmul_idle", 32'(md_busy), 32'd0);

        // ---------------- stall counter saturation ----------------
        cycle_start();
        ex_memrd = 1'b1; ex_wa = 5'd12; id_rt = 5'd12; id_uses_rt = 1'b1;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        check("sat_fffe", 32'(stall_cycles), 32'h0000_FFFE);
        @(negedge clk);
        check("sat_ffff", 32'(stall_cycles), 32'h0000_FFFF);
        repeat (4400) @(posedge clk);
        @(negedge clk);
        check("sat_hold", 32'(stall_cycles), 32'h0000_FFFF);
        check("sat_stall_on", 32'(stall_id), 32'd1);
        cycle_start();
        @(negedge clk);
        check("sat_release", 32'(stall_id), 32'd0);
        check("sat_final", 32'(stall_cycles), 32'h0000_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
